// File: rtl/mc_alu_seq_if.sv
// Bus bundle for mc_alu_seq: operand selects and operands, op select and MD
// launch request in; combinational/registered ALU results and the MD
// handshake and HI/LO registers out.
interface mc_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] sign_imm;
  logic [3:0]       alu_control;
  logic             start;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_src_a, alu_src_b, a, b, pc, sign_imm, alu_control, start,
    input  alu_result, alu_out, zero, busy, done, hi, lo
  );

  modport slave (
    input  alu_src_a, alu_src_b, a, b, pc, sign_imm, alu_control, start,
    output alu_result, alu_out, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/mc_alu_seq.sv
// Multi-cycle datapath ALU: operand muxing, combinational result and zero
// flag, per-cycle ALUOut register, plus an iterative multiply/divide unit
// (one shift-add or restoring-subtract step per cycle) with HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start with an MD opcode
// RUN   | iterating, busy=1, one step per cycle for WIDTH cycles
// DONE  | hi/lo hold the new result, done=1 for this cycle only
module mc_alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MULDIV = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mc_alu_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] src_a, src_b, alu_result, alu_out;
  logic             busy, done;

  logic             is_md, md_signed, md_div, accept, div_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  logic             op_div_q, neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0] opb_q, acc_hi, acc_lo, hi, lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  // Operand selection for SrcA / SrcB
  always_comb begin
    src_a = bus.alu_src_a ? bus.a : bus.pc;
    src_b = bus.b;
    unique case (bus.alu_src_b)
      2'b00: src_b = bus.b;
      2'b01: src_b = WIDTH'(4);
      2'b10: src_b = bus.sign_imm;
      2'b11: src_b = bus.sign_imm << 2;
      default: src_b = bus.b;
    endcase
  end

  // Combinational ALU; unlisted and MD codes give zero
  always_comb begin
    alu_result = '0;
    case (bus.alu_control)
      4'b0010: alu_result = src_a + src_b;
      4'b0110: alu_result = src_a - src_b;
      4'b0000: alu_result = src_a & src_b;
      4'b0001: alu_result = src_a | src_b;
      4'b0011: alu_result = src_a ^ src_b;
      4'b0100: alu_result = ~(src_a | src_b);
      4'b0111: alu_result = WIDTH'($signed(src_a) < $signed(src_b));
      4'b1111: alu_result = WIDTH'(src_a < src_b);
      default: alu_result = '0;
    endcase
  end

  // ALUOut follows the result every cycle, regardless of the MD unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alu_out <= '0;
    else        alu_out <= alu_result;
  end

  // MD opcode decode and operand conditioning at launch
  always_comb begin
    is_md     = (bus.alu_control[3:2] == 2'b10);
    md_signed = ~bus.alu_control[0];
    md_div    = bus.alu_control[1];
    accept    = bus.start && (state == IDLE) && is_md && MULDIV;
    div_zero  = md_div && (src_b == '0);
    a_neg     = md_signed && src_a[WIDTH-1];
    b_neg     = md_signed && src_b[WIDTH-1];
    mag_a     = a_neg ? -src_a : src_a;
    mag_b     = b_neg ? -src_b : src_b;
  end

  // One iteration step plus the sign fix-up applied on the final step
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};
    step_hi   = mul_sum[WIDTH:1];
    step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
    if (op_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
    prod = {step_hi, step_lo};
    if (neg_lo_q) prod = -prod;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (op_div_q) begin
      fix_lo = neg_lo_q ? -step_lo : step_lo;
      fix_hi = neg_hi_q ? -step_hi : step_hi;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MD datapath: operand latch, iteration registers, HI/LO write on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      opb_q    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept) begin
      if (div_zero) begin
        hi <= src_a;
        lo <= '1;
      end else begin
        op_div_q <= md_div;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= md_div && a_neg;
        opb_q    <= mag_b;
        acc_hi   <= '0;
        acc_lo   <= mag_a;
        cnt      <= CW'(WIDTH - 1);
      end
    end else if (state == RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt - 1'b1;
      if (cnt == '0) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

  assign bus.alu_result = alu_result;
  assign bus.alu_out    = alu_out;
  assign bus.zero       = (alu_result == '0);
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.hi         = hi;
  assign bus.lo         = lo;
endmodule
